// File: rtl/wb_aperture_decoder.sv
`default_nettype none
//==============================================================================
// Module      : wb_aperture_decoder
// Description : Wishbone aperture decoder and response mux that sits between
//               the AHB-to-FPGA bridge and NUM_SLV fabric slaves. It decodes
//               per-slave chip selects, muxes read data and ACK back to the
//               bridge with no added latency, and forcibly terminates accesses
//               to unmapped apertures or slaves that stay silent too long.
//               Each forced termination is logged in sticky error status
//               (saturating count, last address, interrupt).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   WB_CLK      in   1               Wishbone clock
//   WB_RST      in   1               synchronous active-high reset
//   WBs_ADR     in   APERWIDTH       byte address from bridge
//   WBs_CYC     in   1               cycle valid
//   WBs_STB     in   1               transfer strobe
//   WBs_WE      in   1               1=write, 0=read
//   WBs_RD_DAT  out  32              read data to bridge
//   WBs_ACK     out  1               transfer acknowledge to bridge
//   Slv_CYC_o   out  NUM_SLV         per-slave cycle select
//   Slv_DAT_i   in   NUM_SLV*32      per-slave read data, slave i = [i*32 +: 32]
//   Slv_ACK_i   in   NUM_SLV         per-slave acknowledge
//   Err_Clr_i   in   1               clears error count and interrupt
//   Err_Int_o   out  1               sticky error interrupt
//   Err_Cnt_o   out  ERR_CNT_WIDTH   saturating count of forced terminations
//   Err_Adr_o   out  APERWIDTH       address of most recent forced termination
//==============================================================================
module wb_aperture_decoder #(
  parameter int                           NUM_SLV            = 2,
  parameter int                           APERWIDTH          = 17,
  parameter int                           APERSIZE           = 9,
  parameter logic [NUM_SLV*APERWIDTH-1:0] BASE_ADR_VEC       = {17'h00800, 17'h00000},
  parameter int                           TIMEOUT            = 7,
  parameter logic [31:0]                  DEFAULT_READ_VALUE = 32'hBADF_ABAC,
  parameter int                           ERR_CNT_WIDTH      = 8
) (
  input  logic                     WB_CLK,
  input  logic                     WB_RST,
  input  logic [APERWIDTH-1:0]     WBs_ADR,
  input  logic                     WBs_CYC,
  input  logic                     WBs_STB,
  input  logic                     WBs_WE,
  output logic [31:0]              WBs_RD_DAT,
  output logic                     WBs_ACK,
  output logic [NUM_SLV-1:0]       Slv_CYC_o,
  input  logic [NUM_SLV*32-1:0]    Slv_DAT_i,
  input  logic [NUM_SLV-1:0]       Slv_ACK_i,
  input  logic                     Err_Clr_i,
  output logic                     Err_Int_o,
  output logic [ERR_CNT_WIDTH-1:0] Err_Cnt_o,
  output logic [APERWIDTH-1:0]     Err_Adr_o
);

  // Decode field occupies the address bits above the aperture size
  // (APERSIZE counts 32-bit words, hence the +2 for byte addressing).
  localparam int FLD_LSB = APERSIZE + 2;
  localparam int FLD_W   = APERWIDTH - FLD_LSB;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     err_int_q, err_int_d;
  logic [APERWIDTH-1:0]     err_adr_q, err_adr_d;

  logic [FLD_W-1:0]         adr_fld;
  logic [NUM_SLV-1:0]       sel;
  logic                     mapped;
  logic                     slv_ack_sel;
  logic [31:0]              slv_dat_sel;
  logic                     req;
  logic                     ack_hit;
  logic                     term_entry;

  // Only the decode field of the address matters here; the word offset and
  // the write strobe pass straight to the slaves on their own buses.
  logic                     unused_inputs;
  assign unused_inputs = ^{WBs_WE, WBs_ADR[FLD_LSB-1:0]};

  assign adr_fld = WBs_ADR[APERWIDTH-1:FLD_LSB];
  assign req     = WBs_CYC & WBs_STB;

  // Aperture decode. Scanning from the top index down lets the lowest
  // matching index overwrite higher ones, so duplicate bases resolve to the
  // lowest slave and sel stays one-hot.
  always_comb begin
    sel    = '0;
    mapped = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (adr_fld == BASE_ADR_VEC[i*APERWIDTH+FLD_LSB +: FLD_W]) begin
        sel    = '0;
        sel[i] = 1'b1;
        mapped = 1'b1;
      end
    end
  end

  // AND-OR response mux; sel is one-hot so at most one term contributes.
  always_comb begin
    slv_ack_sel = 1'b0;
    slv_dat_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      slv_ack_sel = slv_ack_sel | (sel[i] & Slv_ACK_i[i]);
      slv_dat_sel = slv_dat_sel | ({32{sel[i]}} & Slv_DAT_i[i*32 +: 32]);
    end
  end

  assign ack_hit = req & slv_ack_sel;

  // Next-state logic. The request cycle itself counts as the first cycle
  // without an ACK, so cnt equals the cycle index of the access while BUSY
  // and the termination lands in cycle TIMEOUT+1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req && !ack_hit) begin
          if (mapped) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_TERM;
          end
        end
      end
      ST_BUSY: begin
        if (!WBs_CYC || ack_hit) begin
          // Bridge abort or normal completion: no error in either case.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = ST_TERM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign term_entry = (state_q != ST_TERM) && (state_d == ST_TERM);

  // Error logging. A termination arriving together with a clear still counts,
  // so the record of the new error is never lost.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_int_d = err_int_q;
    err_adr_d = err_adr_q;
    if (term_entry) begin
      err_int_d = 1'b1;
      err_adr_d = WBs_ADR;
      if (Err_Clr_i) begin
        err_cnt_d = ERR_CNT_WIDTH'(1);
      end else if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end else if (Err_Clr_i) begin
      err_cnt_d = '0;
      err_int_d = 1'b0;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      err_int_q <= 1'b0;
      err_adr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      err_int_q <= err_int_d;
      err_adr_q <= err_adr_d;
    end
  end

  // Bridge-facing responses. In TERM the decoder answers on its own and any
  // late slave ACK or data is ignored.
  always_comb begin
    WBs_ACK    = 1'b0;
    WBs_RD_DAT = DEFAULT_READ_VALUE;
    if (!WB_RST) begin
      if (state_q == ST_TERM) begin
        WBs_ACK = 1'b1;
      end else if (req) begin
        WBs_ACK = slv_ack_sel;
        if (mapped) begin
          WBs_RD_DAT = slv_dat_sel;
        end
      end
    end
  end

  // Slave selects are withdrawn during termination so a slave that wakes up
  // late cannot complete a transfer the bridge already considers finished.
  assign Slv_CYC_o = (WB_RST || (state_q == ST_TERM) || !WBs_CYC) ? '0 : sel;

  assign Err_Cnt_o = err_cnt_q;
  assign Err_Int_o = err_int_q;
  assign Err_Adr_o = err_adr_q;

endmodule
`default_nettype wire
